ppu_pipeline_sequencer: RTL

//  Sequences the PPU 5-stage pipeline around the decoded control word.
//  - Detects load-use hazards: holds PC and IF/ID, and forces the ID control word to NOP (all 22 bits zero).
//  - Selects EX operand forwarding sources.
//  - Runs the data-memory request/ready handshake, freezing the whole pipeline while memory is busy.
//  - Sits beside the control unit; drives stage latch enables and the ID control-word mux.

---
 rtl/ppu_pipe_pkg.sv | 17 +
 rtl/ppu_forward_sel.sv | 38 +++
 rtl/ppu_pipeline_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_pipe_pkg.sv
// ppu_pipe_pkg: shared encodings for the PPU pipeline sequencer.
//   ppu_state_e      sequencer FSM state (RUN / MEM_WAIT / ERR)
//   FWD_RF..FWD_WB   EX operand forwarding source select codes
package ppu_pipe_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } ppu_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

endpackage

// File: rtl/ppu_forward_sel.sv
// ppu_forward_sel: combinational forwarding source select for one EX operand.
// Ports:
//   src_reg              register specifier read by the ID instruction
//   ex_rf_en/ex_load/ex_rd   EX-stage writer (loads cannot forward from EX)
//   mem_rf_en/mem_rd     MEM-stage writer
//   wb_rf_en/wb_rd       WB-stage writer
//   sel                  00 RF, 01 EX, 10 MEM, 11 WB; youngest writer wins
module ppu_forward_sel
  import ppu_pipe_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] src_reg,
  input  logic             ex_rf_en,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_rf_en,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_rf_en,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    // Register 0 is hard-wired zero and never forwarded.
    if (src_reg != '0) begin
      if (ex_rf_en && !ex_load && (ex_rd == src_reg)) begin
        sel = FWD_EX;
      end else if (mem_rf_en && (mem_rd == src_reg)) begin
        sel = FWD_MEM;
      end else if (wb_rf_en && (wb_rd == src_reg)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ppu_pipeline_sequencer.sv
// ppu_pipeline_sequencer: PPU 5-stage pipeline sequencing beside the control unit.
//   - load-use hazard detection: hold PC and IF/ID, force ID control word to NOP
//   - EX operand forwarding select (two ppu_forward_sel instances)
//   - data-memory request/ready handshake with timeout, freezing the pipeline
// Optional feature: define PPU_STALL_PERF_EN to build saturating stall counters;
// otherwise lu_stall_cnt / mem_wait_cnt are tied to zero.
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   id_rs/id_rt/id_use_rs/id_use_rt   ID-stage source operands
//   ex_load/ex_rf_en/ex_rd        EX-stage instruction
//   mem_rf_en/mem_rd, wb_rf_en/wb_rd  MEM/WB writers
//   mem_access, dmem_ready        MEM-stage access and memory completion
//   pc_le, ifid_le, ctrl_nop, pipe_freeze   stage latch controls
//   dmem_req                      data-memory request
//   fwd_a, fwd_b                  rs/rt forwarding source
//   timeout_err                   sticky memory-timeout flag
//   lu_stall_cnt, mem_wait_cnt    performance counters
module ppu_pipeline_sequencer
  import ppu_pipe_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_load,
  input  logic              ex_rf_en,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              mem_rf_en,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              wb_rf_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_le,
  output logic              ifid_le,
  output logic              ctrl_nop,
  output logic              pipe_freeze,
  output logic              dmem_req,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              timeout_err,
  output logic [PERF_W-1:0] lu_stall_cnt,
  output logic [PERF_W-1:0] mem_wait_cnt
);

  localparam int unsigned WcntW = $clog2(MEM_TIMEOUT);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(MEM_TIMEOUT - 1);
  localparam logic [WcntW-1:0] WcntOne  = WcntW'(1);

  ppu_state_e       state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;

  logic       lu;
  logic       core_freeze;   // freeze demand ignoring reset
  logic       core_bubble;   // load-use bubble ignoring reset
  logic       core_nop;
  logic       core_req;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  assign lu = ex_load && ex_rf_en && (ex_rd != '0) &&
              ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  ppu_forward_sel #(
    .REG_W (REG_W)
  ) u_fwd_rs (
    .src_reg   (id_rs),
    .ex_rf_en  (ex_rf_en),
    .ex_load   (ex_load),
    .ex_rd     (ex_rd),
    .mem_rf_en (mem_rf_en),
    .mem_rd    (mem_rd),
    .wb_rf_en  (wb_rf_en),
    .wb_rd     (wb_rd),
    .sel       (fwd_a_sel)
  );

  ppu_forward_sel #(
    .REG_W (REG_W)
  ) u_fwd_rt (
    .src_reg   (id_rt),
    .ex_rf_en  (ex_rf_en),
    .ex_load   (ex_load),
    .ex_rd     (ex_rd),
    .mem_rf_en (mem_rf_en),
    .mem_rd    (mem_rd),
    .wb_rf_en  (wb_rf_en),
    .wb_rd     (wb_rd),
    .sel       (fwd_b_sel)
  );

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StRun: begin
        // The RUN cycle that sees the miss is the first freeze cycle.
        if (mem_access && !dmem_ready) begin
          state_d = StMemWait;
          wcnt_d  = WcntOne;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
          wcnt_d  = '0;
        end else if (wcnt_q == WcntLast) begin
          state_d   = StErr;
          timeout_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WcntOne;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  // Output logic. Freeze outranks the load-use bubble; in MEM_WAIT the
  // ready cycle falls through to the normal lu check.
  always_comb begin
    core_freeze = 1'b0;
    core_bubble = 1'b0;
    core_nop    = 1'b0;
    core_req    = 1'b0;
    unique case (state_q)
      StRun: begin
        core_req = mem_access;
        if (mem_access && !dmem_ready) begin
          core_freeze = 1'b1;
        end else if (lu) begin
          core_bubble = 1'b1;
        end
      end
      StMemWait: begin
        core_req = mem_access;
        if (!dmem_ready) begin
          core_freeze = 1'b1;
        end else if (lu) begin
          core_bubble = 1'b1;
        end
      end
      default: begin
        core_freeze = 1'b1;
        core_nop    = 1'b1;
      end
    endcase

    if (reset) begin
      pc_le       = 1'b0;
      ifid_le     = 1'b0;
      ctrl_nop    = 1'b1;
      pipe_freeze = 1'b1;
      dmem_req    = 1'b0;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else begin
      pc_le       = !(core_freeze || core_bubble);
      ifid_le     = !(core_freeze || core_bubble);
      ctrl_nop    = core_bubble || core_nop;
      pipe_freeze = core_freeze;
      dmem_req    = core_req;
      fwd_a       = fwd_a_sel;
      fwd_b       = fwd_b_sel;
    end
  end

  assign timeout_err = timeout_q;

`ifdef PPU_STALL_PERF_EN
  logic [PERF_W-1:0] lu_cnt_q, mw_cnt_q;
  logic              lu_inc, mw_inc;

  assign lu_inc = (state_q == StRun) && core_bubble;
  assign mw_inc = core_freeze && (state_q != StErr);

  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      if (lu_inc && (lu_cnt_q != '1)) begin
        lu_cnt_q <= lu_cnt_q + 1'b1;
      end
      if (mw_inc && (mw_cnt_q != '1)) begin
        mw_cnt_q <= mw_cnt_q + 1'b1;
      end
    end
  end

  assign lu_stall_cnt = lu_cnt_q;
  assign mem_wait_cnt = mw_cnt_q;
`else
  assign lu_stall_cnt = '0;
  assign mem_wait_cnt = '0;
`endif

endmodule
